data_mem_responder: RTL and testbench

- Data-memory responder for the MEM stage of the 5-stage MIPS pipeline.
- Services the pipeline's `mem_ren` / `mem_wen` requests with a configurable, multi-cycle latency.
- Raises `mem_stall` back to the pipeline controller so it can freeze IF/ID/EXE/MEM while an access is outstanding.
- Flags misaligned and out-of-range accesses.

---
 rtl/data_mem_responder_pkg.sv | 23 ++
 rtl/data_mem_responder_ram.sv | 29 ++
 rtl/data_mem_responder.sv | 140 ++++++++++++++
 tb/tb_data_mem_responder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the MEM-stage data-memory responder:
// FSM encoding, latency counter width and address-legality helper.
package mem_resp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam int CNT_W      = 4;
   localparam int DATA_W     = 32;
   localparam int BYTE_SHIFT = 2;

   // A byte address is legal when it is word aligned and falls inside
   // the 2^aw word window; everything above the window must be zero.
   function automatic logic addr_ok(input logic [DATA_W-1:0] a, input int aw);
      logic [DATA_W-1:0] w_hi;
      w_hi = a >> (aw + BYTE_SHIFT);
      return (a[BYTE_SHIFT-1:0] == 2'b00) && (w_hi == '0);
   endfunction

endpackage

// File: rtl/data_mem_responder_ram.sv
// Single-port synchronous word RAM with registered read data.
// Contents are deliberately not reset; dout only changes on a read.
module data_ram #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [31:0]           din,
   output logic [31:0]           dout
);

   logic [31:0] r_mem [2**ADDR_WIDTH];
   logic [31:0] r_dout;

   // Word write port.
   always_ff @(posedge clk) begin
      if (we) r_mem[addr] <= din;
   end

   // Registered read; holds its last value between reads.
   always_ff @(posedge clk) begin
      if (re) r_dout <= r_mem[addr];
   end

   assign dout = r_dout;

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data-memory responder: services one load/store at a time
// with a fixed multi-cycle latency, stalls the pipeline while busy and
// flags misaligned, out-of-range or ambiguous (load+store) accesses.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   IDLE    | waiting for a request; stall raised combinationally
//   WAIT    | access outstanding, latency counter running down
//   RESP    | done pulse, read data valid, pipeline advances
module data_mem_responder
   import mem_resp_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_en,
   input  logic        mem_ren,
   input  logic        mem_wen,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_stall,
   output logic        mem_done,
   output logic        addr_err
);

   state_t                  r_state;
   logic [CNT_W-1:0]        r_cnt;
   logic                    r_wr;
   logic                    r_err;
   logic [ADDR_WIDTH-1:0]   r_idx;
   logic [31:0]             r_wdata;
   logic                    r_done;
   logic                    r_addr_err;
   logic                    r_rd_zero;

   logic                    w_req;
   logic                    w_start;
   logic                    w_new_err;
   logic                    w_fire;
   logic                    w_in_idle;
   logic                    w_op_wr;
   logic                    w_op_err;
   logic [ADDR_WIDTH-1:0]   w_op_idx;
   logic [31:0]             w_op_wdata;
   logic                    w_ram_we;
   logic                    w_ram_re;
   logic [31:0]             w_ram_dout;

   assign w_req     = mem_ren | mem_wen;
   assign w_in_idle = (r_state == ST_IDLE);
   assign w_start   = w_in_idle & mem_en & w_req;
   assign w_new_err = ~addr_ok(mem_addr, ADDR_WIDTH) | (mem_ren & mem_wen);

   // The edge that enters RESP commits the access. With single-cycle
   // latency that is the same edge that accepts the request, so the
   // RAM is fed straight from the inputs while still in IDLE.
   assign w_fire = ~rst & mem_en &
                   ((w_start & (LATENCY == 1)) |
                    ((r_state == ST_WAIT) & (r_cnt == CNT_W'(1))));

   assign w_op_wr    = w_in_idle ? mem_wen   : r_wr;
   assign w_op_err   = w_in_idle ? w_new_err : r_err;
   assign w_op_idx   = w_in_idle ? mem_addr[ADDR_WIDTH+1:2] : r_idx;
   assign w_op_wdata = w_in_idle ? mem_wdata : r_wdata;

   assign w_ram_we = w_fire &  w_op_wr & ~w_op_err;
   assign w_ram_re = w_fire & ~w_op_wr & ~w_op_err;

   data_ram #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk  (clk),
      .we   (w_ram_we),
      .re   (w_ram_re),
      .addr (w_op_idx),
      .din  (w_op_wdata),
      .dout (w_ram_dout)
   );

   // Sequencing FSM, latency down-counter and registered response flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_wr       <= 1'b0;
         r_err      <= 1'b0;
         r_idx      <= '0;
         r_wdata    <= '0;
         r_done     <= 1'b0;
         r_addr_err <= 1'b0;
         r_rd_zero  <= 1'b1;
      end else if (mem_en) begin
         case (r_state)
            ST_IDLE: begin
               if (w_req) begin
                  r_wr    <= mem_wen;
                  r_err   <= w_new_err;
                  r_idx   <= mem_addr[ADDR_WIDTH+1:2];
                  r_wdata <= mem_wdata;
                  if (LATENCY == 1) begin
                     r_state <= ST_RESP;
                  end else begin
                     r_cnt   <= CNT_W'(LATENCY - 1);
                     r_state <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) r_state <= ST_RESP;
            end
            ST_RESP: begin
               // Request lines seen here still belong to the finished access.
               r_state    <= ST_IDLE;
               r_done     <= 1'b0;
               r_addr_err <= 1'b0;
            end
            default: r_state <= ST_IDLE;
         endcase

         if (w_fire) begin
            r_done     <= 1'b1;
            r_addr_err <= w_op_err;
            // Read data is forced to zero after an illegal access and
            // otherwise keeps the last successful load.
            if (w_op_err)      r_rd_zero <= 1'b1;
            else if (!w_op_wr) r_rd_zero <= 1'b0;
         end
      end
   end

   assign mem_stall = (r_state == ST_WAIT) | w_start;
   assign mem_done  = r_done;
   assign addr_err  = r_addr_err;
   assign mem_rdata = r_rd_zero ? 32'd0 : w_ram_dout;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: one responder at LATENCY=2 for timing, error, freeze
// and reset cases, one at LATENCY=1 for a store/load sweep.
module tb_data_mem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        a_rst, a_en, a_ren, a_wen;
   logic [31:0] a_addr, a_wdata, a_rdata;
   logic        a_stall, a_done, a_err;

   logic        b_rst, b_en, b_ren, b_wen;
   logic [31:0] b_addr, b_wdata, b_rdata;
   logic        b_stall, b_done, b_err;

   data_mem_responder #(.ADDR_WIDTH(8), .LATENCY(2)) u_dut_a (
      .clk(clk), .rst(a_rst), .mem_en(a_en), .mem_ren(a_ren), .mem_wen(a_wen),
      .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_rdata(a_rdata),
      .mem_stall(a_stall), .mem_done(a_done), .addr_err(a_err)
   );

   data_mem_responder #(.ADDR_WIDTH(8), .LATENCY(1)) u_dut_b (
      .clk(clk), .rst(b_rst), .mem_en(b_en), .mem_ren(b_ren), .mem_wen(b_wen),
      .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_rdata(b_rdata),
      .mem_stall(b_stall), .mem_done(b_done), .addr_err(b_err)
   );

   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drv(input int sel, input logic en, input logic ren, input logic wen,
                      input logic [31:0] addr, input logic [31:0] wdata);
      if (sel == 0) begin
         a_en = en; a_ren = ren; a_wen = wen; a_addr = addr; a_wdata = wdata;
      end else begin
         b_en = en; b_ren = ren; b_wen = wen; b_addr = addr; b_wdata = wdata;
      end
   endtask

   task automatic smp(input int sel, output logic stall, output logic done,
                      output logic err, output logic [31:0] rd);
      if (sel == 0) begin
         stall = a_stall; done = a_done; err = a_err; rd = a_rdata;
      end else begin
         stall = b_stall; done = b_done; err = b_err; rd = b_rdata;
      end
   endtask

   // One access, entered just after a rising edge with the DUT idle.
   // Checks stall for lat cycles, then the RESP cycle; request lines are
   // held through RESP and dropped after it.
   task automatic acc(input int sel, input logic ren, input logic wen,
                      input logic [31:0] addr, input logic [31:0] wdata, input int lat,
                      input logic exp_err, input logic [31:0] exp_rd, input string tag);
      logic st, dn, er;
      logic [31:0] rd;
      drv(sel, 1'b1, ren, wen, addr, wdata);
      for (int c = 0; c < lat; c++) begin
         @(negedge clk);
         smp(sel, st, dn, er, rd);
         chk({tag, ".stall"}, 32'(st), 32'd1);
         chk({tag, ".busy_done"}, 32'(dn), 32'd0);
         @(posedge clk); #1;
      end
      @(negedge clk);
      smp(sel, st, dn, er, rd);
      chk({tag, ".resp_stall"}, 32'(st), 32'd0);
      chk({tag, ".done"}, 32'(dn), 32'd1);
      chk({tag, ".err"}, 32'(er), 32'(exp_err));
      chk({tag, ".rdata"}, rd, exp_rd);
      @(posedge clk); #1;
      drv(sel, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
   endtask

   logic        st, dn, er;
   logic [31:0] rd;
   logic [31:0] b_last;
   logic [31:0] d;

   initial begin
      a_rst = 1'b1; b_rst = 1'b1;
      drv(0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      drv(1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      smp(0, st, dn, er, rd);
      chk("rst.stall", 32'(st), 32'd0);
      chk("rst.done", 32'(dn), 32'd0);
      chk("rst.err", 32'(er), 32'd0);
      chk("rst.rdata", rd, 32'd0);
      smp(1, st, dn, er, rd);
      chk("rst_b.done", 32'(dn), 32'd0);
      chk("rst_b.rdata", rd, 32'd0);
      @(posedge clk); #1;
      a_rst = 1'b0; b_rst = 1'b0;

      // Basic write/read, back to back.
      acc(0, 0, 1, 32'h10,  32'hDEADBEEF, 2, 0, 32'h0,        "wr10");
      acc(0, 1, 0, 32'h10,  32'h0,        2, 0, 32'hDEADBEEF, "rd10");
      // Known background for the error cases; rdata keeps the last load.
      acc(0, 0, 1, 32'h00,  32'hA5A5A5A5, 2, 0, 32'hDEADBEEF, "wr00");
      acc(0, 0, 1, 32'h100, 32'h5A5A0100, 2, 0, 32'hDEADBEEF, "wr100");
      acc(0, 0, 1, 32'h20,  32'h11112222, 2, 0, 32'hDEADBEEF, "wr20");
      acc(0, 0, 1, 32'h04,  32'h0BADF00D, 2, 0, 32'hDEADBEEF, "wr04");
      // Illegal accesses.
      acc(0, 1, 0, 32'h13,  32'h0,        2, 1, 32'h0,        "rd13_misal");
      acc(0, 0, 1, 32'h400, 32'hFFFFFFFF, 2, 1, 32'h0,        "wr400_oor");
      acc(0, 1, 0, 32'h00,  32'h0,        2, 0, 32'hA5A5A5A5, "rd00_after_oor");
      acc(0, 1, 0, 32'h100, 32'h0,        2, 0, 32'h5A5A0100, "rd100_after_oor");
      acc(0, 1, 1, 32'h20,  32'h99999999, 2, 1, 32'h0,        "rw20_both");
      acc(0, 1, 0, 32'h20,  32'h0,        2, 0, 32'h11112222, "rd20_after_both");

      // Freeze for 3 cycles in WAIT of a write.
      drv(0, 1'b1, 1'b0, 1'b1, 32'h30, 32'h12345678);
      @(negedge clk);
      chk("frz.c0_stall", 32'(a_stall), 32'd1);
      @(posedge clk); #1;
      a_en = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("frz.hold_stall", 32'(a_stall), 32'd1);
         chk("frz.hold_done", 32'(a_done), 32'd0);
         @(posedge clk); #1;
      end
      a_en = 1'b1;
      @(negedge clk);
      chk("frz.wait_stall", 32'(a_stall), 32'd1);
      chk("frz.wait_done", 32'(a_done), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("frz.resp_stall", 32'(a_stall), 32'd0);
      chk("frz.resp_done", 32'(a_done), 32'd1);
      chk("frz.resp_err", 32'(a_err), 32'd0);
      chk("frz.resp_rdata", a_rdata, 32'h11112222);
      @(posedge clk); #1;
      drv(0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      acc(0, 1, 0, 32'h30, 32'h0, 2, 0, 32'h12345678, "rd30_after_frz");

      // Reset during WAIT abandons the write.
      drv(0, 1'b1, 1'b0, 1'b1, 32'h04, 32'hCAFEF00D);
      @(negedge clk);
      chk("rstmid.c0_stall", 32'(a_stall), 32'd1);
      @(posedge clk); #1;
      a_rst = 1'b1;
      @(negedge clk);
      chk("rstmid.wait_stall", 32'(a_stall), 32'd1);
      @(posedge clk); #1;
      a_rst = 1'b0;
      drv(0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      @(negedge clk);
      chk("rstmid.stall", 32'(a_stall), 32'd0);
      chk("rstmid.done", 32'(a_done), 32'd0);
      chk("rstmid.err", 32'(a_err), 32'd0);
      chk("rstmid.rdata", a_rdata, 32'd0);
      chk("rstmid.state", 32'(u_dut_a.r_state), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rstmid.no_resp", 32'(a_done), 32'd0);
      @(posedge clk); #1;
      acc(0, 1, 0, 32'h04, 32'h0, 2, 0, 32'h0BADF00D, "rd04_after_rst");

      // LATENCY=1 sweep: store then load each word, then read all back.
      b_last = 32'd0;
      for (int i = 0; i < 16; i++) begin
         d = 32'hC0DE0000 + 32'(i) * 32'h00000111;
         acc(1, 0, 1, 32'(i) * 32'd4, d, 1, 0, b_last, "sw_st");
         acc(1, 1, 0, 32'(i) * 32'd4, 32'd0, 1, 0, d, "sw_ld");
         b_last = d;
         @(negedge clk);
         chk("sw.idle_stall", 32'(b_stall), 32'd0);
         chk("sw.idle_done", 32'(b_done), 32'd0);
         @(posedge clk); #1;
      end
      for (int i = 15; i >= 0; i--) begin
         d = 32'hC0DE0000 + 32'(i) * 32'h00000111;
         acc(1, 1, 0, 32'(i) * 32'd4, 32'd0, 1, 0, d, "sw_rb");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
